// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data widths, the NOP encoding and the
// instruction-memory responder state type.
package riscv_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned IADDR_W = 30;

   // ADDI x0, x0, 0
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

endpackage : riscv_pkg

// File: rtl/riscv_imem_array.sv
// Instruction storage: one synchronous write port and one combinational read
// port. A write to the word being read is forwarded to the read data.
module riscv_imem_array
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [XLEN-1:0]   rdata_c
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   logic [XLEN-1:0] mem_q [DEPTH];

   // Program-load write; contents survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read with write-first bypass on an address collision
   always_comb begin
      rdata_c = mem_q[raddr_i];
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_c = wdata_i;
      end
   end

endmodule : riscv_imem_array

// File: rtl/riscv_imem.sv
// Instruction memory responder for the core fetch port: request/valid
// handshake, programmable wait states and out-of-range fault reporting.
module riscv_imem
   import riscv_pkg::*;
#(
   parameter int unsigned     ADDR_W      = 10,
   parameter int unsigned     WAIT_CYCLES = 1,
   parameter logic [XLEN-1:0] RESET_INST  = INST_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IADDR_W-1:0] inst_addr,
   input  logic               req,
   output logic [XLEN-1:0]    inst,
   output logic               inst_valid,
   output logic               busy,
   output logic               fault,
   input  logic               ld_en,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [XLEN-1:0]    ld_data
);

   localparam int unsigned CNT_W = 4;
   // Counter preload; unused when there are no wait states
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   imem_state_e        state_q;
   logic [IADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [XLEN-1:0]    inst_q;
   logic               valid_q;
   logic               busy_q;
   logic               fault_q;

   logic [XLEN-1:0]    rd_data_c;
   logic               in_range_c;

   riscv_imem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (ld_en),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .raddr_i (addr_q[ADDR_W-1:0]),
      .rdata_c (rd_data_c)
   );

   // No aliasing: any decoded-out upper address bit is a fault
   assign in_range_c = (addr_q[IADDR_W-1:ADDR_W] == '0);

   // Fetch FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         inst_q  <= RESET_INST;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q <= inst_addr;
                  busy_q <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                  end else begin
                     cnt_q   <= CNT_LOAD;
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (in_range_c) begin
                  inst_q <= rd_data_c;
               end else begin
                  inst_q  <= RESET_INST;
                  fault_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign busy       = busy_q;
   assign fault      = fault_q;

endmodule : riscv_imem

// File: tb/tb_riscv_imem.sv
// Bench for riscv_imem: three instances (0, 1 and 4 wait states) share one
// stimulus stream and are each compared against a transaction-level model.
module tb_riscv_imem;
   import riscv_pkg::*;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 32'd1 << AW;
   localparam int          NI    = 3;

   function automatic int unsigned wc(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [29:0] inst_addr;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   logic [31:0] inst_o  [NI];
   logic        valid_o [NI];
   logic        busy_o  [NI];
   logic        fault_o [NI];

   always #5 clk = ~clk;

   riscv_imem #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .req(req),
      .inst(inst_o[0]), .inst_valid(valid_o[0]), .busy(busy_o[0]), .fault(fault_o[0]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   riscv_imem #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .req(req),
      .inst(inst_o[1]), .inst_valid(valid_o[1]), .busy(busy_o[1]), .fault(fault_o[1]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   riscv_imem #(.ADDR_W(AW), .WAIT_CYCLES(4)) u_w4 (
      .clk(clk), .rst(rst), .inst_addr(inst_addr), .req(req),
      .inst(inst_o[2]), .inst_valid(valid_o[2]), .busy(busy_o[2]), .fault(fault_o[2]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   // Reference model: one pending fetch per instance, answered at a due cycle
   logic [31:0] mem_m   [DEPTH];
   bit          m_pend  [NI];
   int unsigned m_due   [NI];
   logic [29:0] m_addr  [NI];
   logic [31:0] m_inst  [NI];
   logic        m_valid [NI];
   logic        m_busy  [NI];
   logic        m_fault [NI];
   int unsigned cyc = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int k,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (wait=%0d) at cycle %0d: got %h, want %h",
                  name, wc(k), cyc, act, exp);
      end
   endtask

   function automatic void model_edge(input int k, input logic r, input logic q,
                                      input logic [29:0] a);
      if (r) begin
         m_pend[k]  = 1'b0;
         m_inst[k]  = INST_NOP;
         m_valid[k] = 1'b0;
         m_busy[k]  = 1'b0;
         m_fault[k] = 1'b0;
      end else if (m_pend[k] && (cyc == m_due[k])) begin
         m_pend[k]  = 1'b0;
         m_valid[k] = 1'b1;
         m_busy[k]  = 1'b0;
         if (m_addr[k] < 30'(DEPTH)) begin
            m_inst[k]  = mem_m[m_addr[k][AW-1:0]];
            m_fault[k] = 1'b0;
         end else begin
            m_inst[k]  = INST_NOP;
            m_fault[k] = 1'b1;
         end
      end else begin
         m_valid[k] = 1'b0;
         m_fault[k] = 1'b0;
         if (!m_pend[k] && q) begin
            m_pend[k] = 1'b1;
            m_addr[k] = a;
            m_due[k]  = cyc + 1 + wc(k);
            m_busy[k] = 1'b1;
         end
      end
   endfunction

   // One clock: drive at negedge, advance the model at posedge, compare after
   task automatic step(input logic r, input logic q, input logic [29:0] a,
                       input logic le, input logic [9:0] la, input logic [31:0] ld);
      @(negedge clk);
      rst = r; req = q; inst_addr = a; ld_en = le; ld_addr = la; ld_data = ld;
      @(posedge clk);
      cyc++;
      if (le) mem_m[la] = ld;
      for (int k = 0; k < NI; k++) model_edge(k, r, q, a);
      #1;
      for (int k = 0; k < NI; k++) begin
         check("inst",  k, inst_o[k],         m_inst[k]);
         check("valid", k, 32'(valid_o[k]),   32'(m_valid[k]));
         check("busy",  k, 32'(busy_o[k]),    32'(m_busy[k]));
         check("fault", k, 32'(fault_o[k]),   32'(m_fault[k]));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 30'd0, 1'b0, 10'd0, 32'd0);
   endtask

   typedef struct {
      logic        r, q;
      logic [29:0] a;
      logic        le;
      logic [9:0]  la;
      logic [31:0] ld;
      logic        ev, eb, ef;
      logic [31:0] ei;
   } vec_t;

   vec_t tbl [14];

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W5  = 32'h0050_0093;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_v [NI];
      int cnt_v   [NI];
      int lat;
      logic [31:0] got_inst;

      // Expected outputs are those of the one-wait-state instance
      tbl[0]  = '{1'b0, 1'b0, 30'd0,     1'b1, 10'd5, W5,           1'b0, 1'b0, 1'b0, NOP};
      tbl[1]  = '{1'b0, 1'b1, 30'd5,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, NOP};
      tbl[2]  = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, NOP};
      tbl[3]  = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b1, 1'b0, 1'b0, W5};
      tbl[4]  = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b0, 1'b0, 1'b0, W5};
      tbl[5]  = '{1'b0, 1'b1, 30'h400,   1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, W5};
      tbl[6]  = '{1'b0, 1'b1, 30'd5,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, W5};
      tbl[7]  = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b1, 1'b0, 1'b1, NOP};
      tbl[8]  = '{1'b0, 1'b1, 30'd7,     1'b1, 10'd7, 32'h11111111, 1'b0, 1'b1, 1'b0, NOP};
      tbl[9]  = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, NOP};
      tbl[10] = '{1'b0, 1'b1, 30'd5,     1'b1, 10'd7, 32'h22222222, 1'b1, 1'b0, 1'b0, 32'h22222222};
      tbl[11] = '{1'b0, 1'b1, 30'd5,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h22222222};
      tbl[12] = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h22222222};
      tbl[13] = '{1'b0, 1'b0, 30'd0,     1'b0, 10'd0, 32'd0,        1'b1, 1'b0, 1'b0, W5};

      rst = 1'b1; req = 1'b0; inst_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

      // Fill every word while held in reset
      for (int i = 0; i < int'(DEPTH); i++)
         step(1'b1, 1'b0, 30'd0, 1'b1, 10'(i), $urandom);

      // Idle after reset
      idle(10);

      // Directed table
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].q, tbl[i].a, tbl[i].le, tbl[i].la, tbl[i].ld);
         check($sformatf("tbl%0d_inst", i),  1, inst_o[1],       tbl[i].ei);
         check($sformatf("tbl%0d_valid", i), 1, 32'(valid_o[1]), 32'(tbl[i].ev));
         check($sformatf("tbl%0d_busy", i),  1, 32'(busy_o[1]),  32'(tbl[i].eb));
         check($sformatf("tbl%0d_fault", i), 1, 32'(fault_o[1]), 32'(tbl[i].ef));
      end

      // Latency sweep with req held through the busy window
      idle(8);
      for (int k = 0; k < NI; k++) begin first_v[k] = -1; cnt_v[k] = 0; end
      for (int s = 1; s <= 20; s++) begin
         step(1'b0, (s <= 4), 30'(s), 1'b0, 10'd0, 32'd0);
         for (int k = 0; k < NI; k++) begin
            if (valid_o[k] === 1'b1) begin
               cnt_v[k]++;
               if (first_v[k] < 0) first_v[k] = s - 1;
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         check("latency",   k, 32'(first_v[k]), 32'(1 + wc(k)));
         check("responses", k, 32'(cnt_v[k]),   (k == 2) ? 32'd1 : 32'd2);
      end

      // Reset two cycles after accept aborts the four-wait-state fetch
      idle(8);
      step(1'b0, 1'b1, 30'd9, 1'b0, 10'd0, 32'd0);
      idle(1);
      step(1'b1, 1'b0, 30'd0, 1'b0, 10'd0, 32'd0);
      step(1'b1, 1'b0, 30'd0, 1'b0, 10'd0, 32'd0);
      check("rst_busy", 2, 32'(busy_o[2]), 32'd0);
      check("rst_inst", 2, inst_o[2], NOP);
      cnt_v[2] = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 30'd0, 1'b0, 10'd0, 32'd0);
         if (valid_o[2] === 1'b1) cnt_v[2]++;
      end
      check("aborted_resp", 2, 32'(cnt_v[2]), 32'd0);
      step(1'b0, 1'b1, 30'd9, 1'b0, 10'd0, 32'd0);
      lat = -1;
      got_inst = '0;
      for (int s = 1; s <= 10 && lat < 0; s++) begin
         step(1'b0, 1'b0, 30'd0, 1'b0, 10'd0, 32'd0);
         if (valid_o[2] === 1'b1) begin lat = s; got_inst = inst_o[2]; end
      end
      check("post_rst_latency", 2, 32'(lat), 32'd5);
      check("post_rst_inst",    2, got_inst, mem_m[9]);

      // Random traffic including collisions, faults and occasional resets
      for (int i = 0; i < 600; i++) begin
         logic        r, q, le;
         logic [29:0] a;
         logic [9:0]  la;
         r  = ($urandom_range(0, 49) == 0);
         q  = ($urandom_range(0, 1) == 1);
         a  = ($urandom_range(0, 7) == 0) ? (30'($urandom) | 30'h400)
                                          : 30'($urandom_range(0, 1023));
         le = ($urandom_range(0, 3) == 0);
         la = ($urandom_range(0, 1) == 0) ? a[9:0] : 10'($urandom);
         step(r, q, a, le, la, $urandom);
      end

      idle(8);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_riscv_imem

// File: doc/riscv_imem.md
Name: riscv_imem

Overview:
Instruction memory responder on the other end of the core's fetch interface: accepts the word address `inst_addr[29:0]` and returns the 32-bit `inst`. It adds a request/valid handshake, a programmable wait-state counter and range checking, so the core can be exercised against slow memory. A separate load port lets the testbench or boot logic write program words before or between fetches.

Parameters:
ADDR_W, 10, word-address bits actually decoded; depth = 2**ADDR_W words
WAIT_CYCLES, 1, extra cycles between request accept and response (0..15)
RESET_INST, 32'h00000013, value driven on `inst` when no valid data (ADDI x0,x0,0 = NOP)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
inst_addr  input  30  word address from core (byte address bits [31:2])
req  input  1  fetch request; sampled only when busy=0
inst  output  32  fetched instruction; holds last value until next response
inst_valid  output  1  one-cycle pulse: inst is the response to the accepted request
busy  output  1  request in flight; req ignored while high
fault  output  1  one-cycle pulse with inst_valid when accepted address >= 2**ADDR_W
ld_en  input  1  write strobe for program load
ld_addr  input  ADDR_W  load word address
ld_data  input  32  load data

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, inst=RESET_INST, inst_valid=0, busy=0, fault=0, wait counter=0. Array contents are NOT cleared. Reset mid-transaction aborts it; no response is ever produced for the aborted request.
- States: IDLE, WAIT, RESP.
- IDLE: if req=1, latch inst_addr into addr_q and set busy=1. If WAIT_CYCLES=0, go to RESP; otherwise load cnt=WAIT_CYCLES-1 and go to WAIT. If req=0, stay.
- WAIT: if cnt=0 go to RESP, else cnt-=1. busy=1.
- RESP: array is read at addr_q[ADDR_W-1:0].
  - In range (addr_q[29:ADDR_W]==0): inst=word, fault=0.
  - Out of range: inst=RESET_INST, fault=1.
  - inst_valid=1 for exactly this cycle; next state IDLE; busy drops with the registered outputs.
- Latency: req accepted at edge N produces inst_valid at edge N+1+WAIT_CYCLES (2 cycles for the default).
- Back-to-back: a req asserted in the cycle inst_valid is high is accepted at the next edge. Maximum throughput is one fetch per 2+WAIT_CYCLES cycles.
- Load port:
  - ld_en writes ld_data at ld_addr at posedge, in any state, including during reset.
  - If the write hits the same word as a read in RESP, the response returns the NEW data (write-first).
- inst_addr changing while busy=1 has no effect (addr_q is latched).
- Address wrap: none; any upper bit set causes a fault, and there is no aliasing.

Decomposition:
- Shared package riscv_pkg:
  - constant INST_NOP = 32'h00000013
  - imem state enum {IDLE, WAIT, RESP}
  - XLEN=32
  - IADDR_W=30
- Sub-module riscv_imem_array: single read port, single write port, synchronous-write array of 2**ADDR_W x 32 with write-first bypass. The FSM, counter and range check stay in riscv_imem.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> inst=32'h00000013, inst_valid=0, busy=0, fault=0 for 10 cycles.
- Basic fetch (WAIT_CYCLES=1): ld word 5 = 32'h00500093; req=1, inst_addr=5 at edge N -> busy=1 at N, inst_valid=1 with inst=32'h00500093 at N+2, busy=0 after.
- Wait-state sweep: WAIT_CYCLES=0 and WAIT_CYCLES=4 -> inst_valid at N+1 and N+5 respectively; req pulses while busy produce no extra responses.
- Out of range (ADDR_W=10): inst_addr=30'h400 -> inst=32'h00000013, fault=1 and inst_valid=1 in the same cycle; next in-range fetch has fault=0.
- Write-first collision: fetch addr 7 (old 32'h11111111) with ld_en, ld_addr=7, ld_data=32'h22222222 in the RESP cycle -> inst=32'h22222222.
- Reset mid-fetch: WAIT_CYCLES=4, assert rst 2 cycles after accept -> no inst_valid; busy=0; inst=NOP; the following request completes normally.
